// File: rtl/key_ctrl_pkg.sv
// Shared types and width helpers for the push-button controller.
// Used by key_debounce_fsm and key_input_ctrl.
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } key_state_e;

    // Bits needed to hold 0..stable_ticks.
    function automatic int cnt_width(input int stable_ticks);
        return (stable_ticks < 2) ? 1 : $clog2(stable_ticks + 1);
    endfunction

    function automatic int rep_width(input int repeat_delay);
        return (repeat_delay < 2) ? 1 : $clog2(repeat_delay + 1);
    endfunction

    // Bits needed to hold 0..tick_div-1.
    function automatic int tick_width(input int tick_div);
        return (tick_div < 3) ? 1 : $clog2(tick_div);
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop synchroniser, debounce FSM and optional auto-repeat.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_fsm
    import key_ctrl_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic enable_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int               CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_TICKS);
    localparam bit               INSTANT  = (STABLE_TICKS == 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    if (STABLE_TICKS < 1 ||
        (AUTOREPEAT && (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY))) begin : g_param_check
        $error("key_debounce_fsm: invalid debounce/repeat parameters");
    end

    logic [1:0]       sync_q;
    logic             key_sync;
    logic             step;
    logic             repeat_fire;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    assign key_sync = sync_q[1];
    assign step     = tick_i & enable_i;
    assign cnt_inc  = cnt_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (step) begin
            case (state_q)
                IDLE: begin
                    if (key_sync) begin
                        if (INSTANT) begin
                            state_d = HELD;
                            level_d = 1'b1;
                            press_d = 1'b1;
                        end else begin
                            state_d = DEB_PRESS;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!key_sync) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!key_sync) begin
                        if (INSTANT) begin
                            state_d   = IDLE;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = DEB_RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end else begin
                        press_d = repeat_fire;
                    end
                end
                DEB_RELEASE: begin
                    // A bounce back high returns to HELD without touching the repeat counter.
                    if (key_sync) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int               REP_W      = rep_width(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_inc;

    assign rep_inc = rep_q + REP_W'(1);

    always_comb begin
        rep_d       = rep_q;
        repeat_fire = 1'b0;
        if (step) begin
            case (state_q)
                IDLE, DEB_PRESS: rep_d = '0;
                HELD: begin
                    if (key_sync && (rep_q != '1)) begin
                        if (rep_inc == REP_FIRE) begin
                            repeat_fire = 1'b1;
                            rep_d       = REP_RELOAD;
                        end else begin
                            rep_d = rep_inc;
                        end
                    end
                end
                default: rep_d = rep_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Push-button controller: shared sample tick plus one debounce FSM per key.
// Define KEY_AUTOREPEAT_EN to add held-key auto-repeat press pulses.
module key_input_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_event
);

    localparam int                TICK_W    = tick_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    if (TICK_DIV < 2 || NUM_KEYS < 1) begin : g_param_check
        $error("key_input_ctrl: TICK_DIV must be >= 2 and NUM_KEYS >= 1");
    end

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    always_comb begin
        tick       = enable && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_fsm #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .enable_i  (enable),
            .key_i     (key_in[k]),
            .level_o   (key_level[k]),
            .press_o   (key_press[k]),
            .release_o (key_release[k])
        );
    end

    assign any_event = |(key_press | key_release);

endmodule

// File: tb/tb_key_input_ctrl.sv
// Self-checking bench for key_input_ctrl with a 4-cycle tick and 3-tick debounce.
module tb_key_input_ctrl;

    localparam int NK = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_event;

    key_input_ctrl #(
        .NUM_KEYS     (NK),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .any_event   (any_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NK-1:0] keys;
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
    } vec_t;

    vec_t          vecs [17];
    vec_t          sb_q [$];
    int            checks   = 0;
    int            failures = 0;
    logic [NK-1:0] cur_level;

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_level"}, key_level, cur_level);
        check({name, "_pulse"}, key_press | key_release, '0);
        check({name, "_any"}, {3'b000, any_event}, 4'b0000);
    endtask

    // Drive one tick period of key input, then compare the outputs produced by the tick edge.
    task automatic run_tick(input string name, input logic [NK-1:0] keys, input logic [NK-1:0] lvl,
                            input logic [NK-1:0] prs, input logic [NK-1:0] rel);
        vec_t exp_v;
        key_in      = keys;
        exp_v.keys  = keys;
        exp_v.level = lvl;
        exp_v.press = prs;
        exp_v.rel   = rel;
        sb_q.push_back(exp_v);
        for (int c = 0; c < TD; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < TD - 1) check_quiet({name, "_between"});
        end
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
        end else begin
            exp_v = sb_q.pop_front();
            check({name, "_level"},   key_level,   exp_v.level);
            check({name, "_press"},   key_press,   exp_v.press);
            check({name, "_release"}, key_release, exp_v.rel);
            check({name, "_any"}, {3'b000, any_event}, {3'b000, |(exp_v.press | exp_v.rel)});
            cur_level = exp_v.level;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NK-1:0] exp_p;

        // keys, level after tick, press pulse, release pulse
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
        vecs[3]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
        vecs[6]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
        vecs[10] = '{4'b0011, 4'b0001, 4'b0001, 4'b0000};
        vecs[11] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000};
        vecs[12] = '{4'b0000, 4'b0011, 4'b0000, 4'b0000};
        vecs[13] = '{4'b0001, 4'b0011, 4'b0000, 4'b0000};
        vecs[14] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010};
        vecs[15] = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};

        rst       = 1'b0;
        enable    = 1'b1;
        key_in    = 4'b1111;
        cur_level = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_level",   key_level,   4'b0000);
        check("reset_press",   key_press,   4'b0000);
        check("reset_release", key_release, 4'b0000);
        check("reset_any", {3'b000, any_event}, 4'b0000);

        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            run_tick($sformatf("vec%0d", i), vecs[i].keys, vecs[i].level, vecs[i].press, vecs[i].rel);
        end

        // Freeze during DEB_PRESS: two high samples taken, one still needed.
        run_tick("frz_pre0", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        run_tick("frz_pre1", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        enable = 1'b0;
        for (int c = 0; c < TD * 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("frz_hold");
        end
        enable = 1'b1;
        run_tick("frz_accept", 4'b0100, 4'b0100, 4'b0100, 4'b0000);

        // Hold key 2 for 20 ticks.
        for (int k = 1; k <= 20; k++) begin
            exp_p = 4'b0000;
`ifdef KEY_AUTOREPEAT_EN
            if (k >= RD && ((k - RD) % RR) == 0) exp_p = 4'b0100;
`endif
            run_tick($sformatf("hold%0d", k), 4'b0100, 4'b0100, exp_p, 4'b0000);
        end

        // Asynchronous reset while key 2 is HELD, between clock edges.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_level",   key_level,   4'b0000);
        check("async_rst_press",   key_press,   4'b0000);
        check("async_rst_release", key_release, 4'b0000);
        check("async_rst_any", {3'b000, any_event}, 4'b0000);
        key_in    = 4'b0000;
        cur_level = 4'b0000;
        repeat (2) @(negedge clk);
        check_quiet("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_tick($sformatf("post_rst%0d", i), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
